// File: rtl/poly_mult_sequencer.sv
// poly_mult_sequencer
// Board-side front end for the polynomial multiplier core. Operand A and
// then B are taken from the slide switches, one per step press. The core is
// launched and watched with a timeout. The product coefficients are then
// shown on the LEDs, one per step press.
//
// Ports
//   man_clk    : single clock, rising edge
//   man_reset  : asynchronous, active-high reset
//   bits       : switch word; coefficient i = bits[i*CW +: CW]
//   step       : advance request, level-sampled on every edge
//   mul_a/b    : operands to the core (registered, stable from START to SHOW)
//   mul_start  : one-cycle launch pulse (START state)
//   mul_done   : core completion strobe, honoured only in WAIT
//   mul_prod   : product coefficients, k = mul_prod[k*PW +: PW]
//   LED        : display (switch echo / busy / coefficient / error pattern)
//   busy       : high in START and WAIT
//   err        : high in ERR
module poly_mult_sequencer #(
  parameter int N       = 4,
  parameter int CW      = 4,
  parameter int PW      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                    man_clk,
  input  logic                    man_reset,
  input  logic [15:0]             bits,
  input  logic                    step,
  output logic [N*CW-1:0]         mul_a,
  output logic [N*CW-1:0]         mul_b,
  output logic                    mul_start,
  input  logic                    mul_done,
  input  logic [(2*N-1)*PW-1:0]   mul_prod,
  output logic [15:0]             LED,
  output logic                    busy,
  output logic                    err
);

  localparam int NP  = 2*N-1;               // product coefficient count
  localparam int IW  = $clog2(NP);          // coefficient index width
  localparam int NS  = 2**IW;               // index space (padded)
  localparam int CTW = $clog2(TIMEOUT+1);   // timeout counter width

  localparam logic [IW-1:0]  LAST_IDX = IW'(NP-1);
  localparam logic [CTW-1:0] LAST_CNT = CTW'(TIMEOUT-1);

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_SHOW,
    S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [N*CW-1:0]         a_q, a_d;
  logic [N*CW-1:0]         b_q, b_d;
  logic [NP*PW-1:0]        prod_q, prod_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CTW-1:0]          cnt_q, cnt_d;

  // Unpack the captured product into an index-addressable array. The array
  // is padded to a power of two so any index value selects a defined word.
  logic [NS-1:0][PW-1:0]   coef;
  logic [PW-1:0]           coef_sel;

  for (genvar k = 0; k < NS; k++) begin : g_coef
    if (k < NP) begin : g_used
      assign coef[k] = prod_q[k*PW +: PW];
    end else begin : g_pad
      assign coef[k] = '0;
    end
  end

  assign coef_sel = coef[idx_q];

  assign mul_a = a_q;
  assign mul_b = b_q;

  always_ff @(posedge man_clk or posedge man_reset) begin
    if (man_reset) begin
      state_q <= S_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    idx_d     = idx_q;
    cnt_d     = '0;       // counter only runs while in WAIT
    mul_start = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    LED       = bits;

    case (state_q)
      S_LOAD_A: begin
        if (step) begin
          a_d     = bits;
          state_d = S_LOAD_B;
        end
      end

      S_LOAD_B: begin
        if (step) begin
          b_d     = bits;
          state_d = S_START;
        end
      end

      // Launch cycle: step and mul_done are both ignored here.
      S_START: begin
        mul_start = 1'b1;
        busy      = 1'b1;
        LED       = 16'h8000;
        state_d   = S_WAIT;
      end

      // Done takes priority over an expiring timeout in the same cycle.
      S_WAIT: begin
        busy = 1'b1;
        LED  = 16'h8000;
        if (mul_done) begin
          prod_d  = mul_prod;
          idx_d   = '0;
          state_d = S_SHOW;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHOW: begin
        LED = {4'(idx_q), 12'(coef_sel)};
        if (step) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_LOAD_A;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_ERR: begin
        err = 1'b1;
        LED = 16'hE000;
        if (step) state_d = S_LOAD_A;
      end

      default: state_d = S_LOAD_A;
    endcase
  end

endmodule

// File: tb/tb_poly_mult_sequencer.sv
module tb_poly_mult_sequencer;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int PW = 10;
  localparam int TO = 64;

  logic        man_clk = 1'b0;
  logic        man_reset;
  logic [15:0] bits;
  logic        step;
  logic [15:0] mul_a, mul_b;
  logic        mul_start;
  logic        mul_done;
  logic [(2*N-1)*PW-1:0] mul_prod;
  logic [15:0] LED;
  logic        busy, err;

  poly_mult_sequencer #(.N(N), .CW(CW), .PW(PW), .TIMEOUT(TO)) dut (
    .man_clk(man_clk), .man_reset(man_reset), .bits(bits), .step(step),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_done(mul_done),
    .mul_prod(mul_prod), .LED(LED), .busy(busy), .err(err)
  );

  always #5 man_clk = ~man_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model core: done follows the start pulse by auto_dly cycles; the product
  // is the schoolbook convolution of the presented operands.
  logic        auto_en;
  logic        man_done;
  int          auto_dly;
  logic [15:0] sp;
  int          n_start = 0;

  always @(posedge man_clk or posedge man_reset)
    if (man_reset) sp <= '0;
    else           sp <= {sp[14:0], mul_start};

  always @(posedge man_clk)
    if (mul_start) n_start <= n_start + 1;

  assign mul_done = man_done | (auto_en & sp[auto_dly-1]);

  function automatic logic [(2*N-1)*PW-1:0] pmul(input logic [15:0] a, input logic [15:0] b);
    logic [(2*N-1)*PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[(i+j)*PW +: PW] = r[(i+j)*PW +: PW] + PW'(a[i*CW +: CW]) * PW'(b[j*CW +: CW]);
    return r;
  endfunction

  always_comb mul_prod = pmul(mul_a, mul_b);

  typedef struct {
    logic [15:0]       a;
    logic [15:0]       b;
    int                dly;
    logic [0:6][15:0]  led;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge man_clk);
    #1;
  endtask

  task automatic do_step;
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  // Leaves the bench one delta past the edge that entered START.
  task automatic load(input logic [15:0] a, input logic [15:0] b);
    bits = a;
    do_step();
    bits = b;
    do_step();
  endtask

  task automatic wait_show(input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    chk("show_reached_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input int v);
    int s0;
    s0       = n_start;
    auto_en  = 1'b1;
    auto_dly = vt[v].dly;
    load(vt[v].a, vt[v].b);
    chk($sformatf("v%0d_start", v), 32'(mul_start), 32'd1);
    chk($sformatf("v%0d_mul_a", v), 32'(mul_a), 32'(vt[v].a));
    chk($sformatf("v%0d_mul_b", v), 32'(mul_b), 32'(vt[v].b));
    tick();
    chk($sformatf("v%0d_start_drop", v), {31'd0, mul_start, busy}, 32'd1);
    wait_show(200);
    chk($sformatf("v%0d_err", v), 32'(err), 32'd0);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("v%0d_led%0d", v, k), 32'(LED), 32'(vt[v].led[k]));
      do_step();
    end
    chk($sformatf("v%0d_back_load_a", v), 32'(LED), 32'(bits));
    chk($sformatf("v%0d_one_start", v), 32'(n_start - s0), 32'd1);
  endtask

  initial begin
    int s0;
    logic bad;

    vt[0] = '{16'h1010, 16'h4321, 5,
              {16'h0000, 16'h1001, 16'h2002, 16'h3004, 16'h4006, 16'h5003, 16'h6004}};
    vt[1] = '{16'h0001, 16'h000F, 1,
              {16'h000F, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000}};
    vt[2] = '{16'hFFFF, 16'hFFFF, 3,
              {16'h00E1, 16'h11C2, 16'h22A3, 16'h3384, 16'h42A3, 16'h51C2, 16'h60E1}};
    vt[3] = '{16'h0021, 16'h0003, 2,
              {16'h0003, 16'h1006, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000}};

    man_reset = 1'b1;
    step      = 1'b0;
    bits      = 16'hA5C3;
    man_done  = 1'b0;
    auto_en   = 1'b0;
    auto_dly  = 1;
    #1;
    chk("rst_led_echo", 32'(LED), 32'h0000A5C3);
    chk("rst_flags", {29'd0, mul_start, busy, err}, 32'd0);
    chk("rst_ops", {mul_a, mul_b}, 32'd0);
    tick();
    tick();
    man_reset = 1'b0;
    tick();

    // Nominal runs, back to back.
    for (int v = 0; v < 4; v++) run_vec(v);

    // Reset in the middle of WAIT, with a nonzero product still captured.
    auto_en = 1'b0;
    load(16'h1234, 16'h5678);
    tick();
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    man_reset = 1'b1;
    #1;
    chk("rstw_flags", {29'd0, mul_start, busy, err}, 32'd0);
    chk("rstw_ops", {mul_a, mul_b}, 32'd0);
    chk("rstw_prod", 32'(|dut.prod_q), 32'd0);
    s0 = n_start;
    tick();
    man_reset = 1'b0;
    bits      = 16'hBEEF;
    tick();
    chk("rstw_load_a", {15'd0, busy, LED}, 32'h0000BEEF);
    chk("rstw_no_start", 32'(n_start - s0), 32'd0);

    // Core never answers: ERR on the 64th edge after entering WAIT.
    load(16'h0021, 16'h0003);
    tick();
    bad = 1'b0;
    for (int c = 1; c < TO; c++) begin
      tick();
      if (err || !busy) bad = 1'b1;
    end
    chk("to_not_early", 32'(bad), 32'd0);
    tick();
    chk("to_err", {15'd0, err, LED}, 32'h0001E000);
    chk("to_busy", 32'(busy), 32'd0);
    bits = 16'h0C0C;
    do_step();
    chk("to_back_load_a", {15'd0, err, LED}, 32'h00000C0C);

    // Done during START ignored; done on the last timeout cycle wins.
    load(16'h0021, 16'h0003);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("start_done_ignored", {15'd0, busy, LED}, 32'h00018000);
    for (int c = 1; c < TO; c++) tick();
    chk("bound_still_wait", {30'd0, busy, err}, 32'd2);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("bound_show", {14'd0, busy, err, LED}, 32'h00000003);
    for (int k = 0; k < 7; k++) do_step();
    chk("bound_back_load_a", 32'(LED), 32'(bits));

    // Step held high from LOAD_A through START and WAIT.
    s0       = n_start;
    auto_en  = 1'b1;
    auto_dly = 5;
    bits     = 16'hFFFF;
    step     = 1'b1;
    tick();
    tick();
    chk("held_start", 32'(mul_start), 32'd1);
    tick();
    bits = 16'h1234;
    bad  = 1'b0;
    for (int c = 0; c < 50 && busy; c++) begin
      if (mul_a !== 16'hFFFF || mul_b !== 16'hFFFF) bad = 1'b1;
      tick();
    end
    step = 1'b0;
    chk("held_ops_stable", 32'(bad), 32'd0);
    chk("held_show_idx0", {15'd0, busy, LED}, 32'h000000E1);
    chk("held_one_start", 32'(n_start - s0), 32'd1);
    do_step();
    chk("held_show_idx1", 32'(LED), 32'h000011C2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
